bcd_adder_4: RTL and testbench
==============================

BCD_ADDER_4 -- requirements
Module: bcd_adder_4

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 A  input  4  BCD addend digit, 0-9 legal.
REQ-005 B  input  4  BCD addend digit, 0-9 legal.
REQ-006 cin  input  1  decimal carry-in from the lower digit.
REQ-007 in_valid  input  1  qualifies A, B and cin for the current cycle.
REQ-008 s0  output  4  registered BCD sum digit (units).
REQ-009 s1  output  4  registered carry digit, {3'b000, carry}; value 0 or 1 only.
REQ-010 out_valid  output  1  high for exactly the cycle after an accepted in_valid.
REQ-011 err  output  1  registered invalid-digit flag; present only when BCD_ADDER_4_ERR_EN is defined.

Function
REQ-012 The block SHALL compute bin = A + B + cin as an unsigned 5-bit value, range 0-31.
REQ-013 If bin > 9, the block SHALL set s0 = (bin + 6)[3:0] and carry = 1.
REQ-014 If bin <= 9, the block SHALL set s0 = bin[3:0] and carry = 0.
REQ-015 For legal digits this SHALL yield the decimal result: s1*10 + s0 = A + B + cin, range 0-19.
REQ-016 Latency SHALL be 1 clock: a cycle with in_valid=1 updates s0, s1 and out_valid=1 at the next rising edge.
REQ-017 Cycles with in_valid=0 SHALL hold s0 and s1 and drive out_valid=0.
REQ-018 Back-to-back in_valid SHALL be accepted every cycle with no bubbles and no backpressure.
REQ-019 s1[3:1] SHALL always read 0; it is legal to chain s1[0] into the cin of the next digit.
REQ-020 Illegal digits (A or B > 9) SHALL still follow REQ-012 to REQ-014 with no special casing, e.g. 15+15+1 gives s0=5, s1=1.

Reset
REQ-021 With rst=1 at a rising edge, the block SHALL force s0=0, s1=0, out_valid=0 and err=0.
REQ-022 Reset SHALL take priority over a simultaneous in_valid; that input is discarded.
REQ-023 Reset asserted mid-stream SHALL drop the in-flight result; the first in_valid after rst deasserts produces output one cycle later.

Configuration
REQ-024 Macro BCD_ADDER_4_ERR_EN defined: the err port SHALL exist.
- err registers (A > 9) || (B > 9), updated under the same in_valid and rst rules as s0.
REQ-025 Macro BCD_ADDER_4_ERR_EN undefined: the err port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-026 Sequence A=1, B=3, cin=0, in_valid=1 -> next cycle s0=4, s1=0, out_valid=1.
REQ-027 Back-to-back inputs (5,7,0) then (6,4,1) -> consecutive outputs (s0=2, s1=1) then (s0=1, s1=1); out_valid stays high.
REQ-028 Boundary cases:
- 9+1+0 -> s0=0, s1=1.
- 9+9+1 -> s0=9, s1=1.
- 0+0+0 -> s0=0, s1=0.
REQ-029 Issue 8+8+0 with in_valid=1 and rst=1 in the same cycle -> outputs all 0; then in_valid=0 for 3 cycles -> outputs held, out_valid=0.
REQ-030 Issue 15+15+1 -> s0=5, s1=1; with BCD_ADDER_4_ERR_EN defined, err=1; a following legal input 2+2+0 clears err to 0.

Source files
------------

// File: rtl/bcd_adder_4_if.sv
// Handshake bundle for the single-digit BCD adder: operands in, registered digits out.
// The err signal exists only when BCD_ADDER_4_ERR_EN is defined.
interface bcd_adder_4_if;
    logic [3:0] A;
    logic [3:0] B;
    logic       cin;
    logic       in_valid;
    logic [3:0] s0;
    logic [3:0] s1;
    logic       out_valid;
`ifdef BCD_ADDER_4_ERR_EN
    logic       err;
`endif

    modport master (
        output A, B, cin, in_valid,
        input  s0, s1, out_valid
`ifdef BCD_ADDER_4_ERR_EN
        , input err
`endif
    );

    modport slave (
        input  A, B, cin, in_valid,
        output s0, s1, out_valid
`ifdef BCD_ADDER_4_ERR_EN
        , output err
`endif
    );
endinterface

// File: rtl/bcd_adder_4.sv
// One-digit BCD adder with carry-in and a single register stage on the outputs.
// Define BCD_ADDER_4_ERR_EN to add the registered invalid-digit flag (err).
module bcd_adder_4 (
    input  logic          clk,
    input  logic          rst,
    bcd_adder_4_if.slave  bus
);

    logic [4:0] bin;
    logic [3:0] sum_digit;
    logic       carry;

    logic [3:0] s0_q;
    logic       carry_q;
    logic       valid_q;

    // Illegal digits take the same +6 correction path; only the low nibble is kept.
    always_comb begin
        bin = {1'b0, bus.A} + {1'b0, bus.B} + {4'b0000, bus.cin};
        if (bin > 5'd9) begin
            sum_digit = bin[3:0] + 4'd6;
            carry     = 1'b1;
        end else begin
            sum_digit = bin[3:0];
            carry     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q    <= 4'd0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s0_q    <= sum_digit;
                carry_q <= carry;
            end
        end
    end

    assign bus.s0        = s0_q;
    assign bus.s1        = {3'b000, carry_q};
    assign bus.out_valid = valid_q;

`ifdef BCD_ADDER_4_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.in_valid) begin
            err_q <= (bus.A > 4'd9) || (bus.B > 4'd9);
        end
    end

    assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_bcd_adder_4.sv
// Self-checking bench for bcd_adder_4: directed steps feed a scoreboard queue that
// is drained and compared one cycle later when the registered outputs appear.
module tb_bcd_adder_4;

    logic clk;
    logic rst;

    bcd_adder_4_if bus ();

    bcd_adder_4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] s0;
        logic [3:0] s1;
        logic       err;
    } exp_t;

    exp_t sb[$];

    int assertCount = 0;
    int failCount   = 0;

    logic [3:0] heldS0  = 4'd0;
    logic [3:0] heldS1  = 4'd0;
    logic       heldErr = 1'b0;

    // Legal digits use decimal division; illegal ones fall back to the raw +6 rule.
    function automatic exp_t model(input int a, input int b, input int c);
        exp_t e;
        int   sum;
        sum = a + b + c;
        if (a <= 9 && b <= 9) begin
            e.s1 = 4'(sum / 10);
            e.s0 = 4'(sum % 10);
        end else if (sum > 9) begin
            e.s1 = 4'd1;
            e.s0 = 4'((sum + 6) % 16);
        end else begin
            e.s1 = 4'd0;
            e.s0 = 4'(sum);
        end
        e.err = (a > 9) || (b > 9);
        return e;
    endfunction

    task automatic compare(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input bit expValid, input bit wasReset);
        exp_t e;
        if (wasReset) begin
            heldS0  = 4'd0;
            heldS1  = 4'd0;
            heldErr = 1'b0;
        end else if (expValid) begin
            if (sb.size() == 0) begin
                assertCount++;
                failCount++;
                $error("[TB] FAIL scoreboard_underflow: observed 0 entries expected 1");
            end else begin
                e       = sb.pop_front();
                heldS0  = e.s0;
                heldS1  = e.s1;
                heldErr = e.err;
            end
        end
        compare("out_valid", {7'd0, bus.out_valid}, {7'd0, expValid});
        compare("s0", {4'd0, bus.s0}, {4'd0, heldS0});
        compare("s1", {4'd0, bus.s1}, {4'd0, heldS1});
`ifdef BCD_ADDER_4_ERR_EN
        compare("err", {7'd0, bus.err}, {7'd0, heldErr});
`endif
    endtask

    // Drive on the falling edge, sample 1 time unit after the capturing rising edge.
    task automatic applyStimulus(input int a, input int b, input int c, input int v, input int r);
        @(negedge clk);
        bus.A        = 4'(a);
        bus.B        = 4'(b);
        bus.cin      = c[0];
        bus.in_valid = v[0];
        rst          = r[0];
        if (r != 0) sb.delete();
        else if (v != 0) sb.push_back(model(a, b, c));
        @(posedge clk);
        #1;
        checkOutput((v != 0) && (r == 0), r != 0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.A        = 4'd0;
        bus.B        = 4'd0;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b0;

        $display("[TB] reset");
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);

        $display("[TB] simple add and back-to-back");
        applyStimulus(1, 3, 0, 1, 0);
        applyStimulus(5, 7, 0, 1, 0);
        applyStimulus(6, 4, 1, 1, 0);

        $display("[TB] boundaries");
        applyStimulus(9, 1, 0, 1, 0);
        applyStimulus(9, 9, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);

        $display("[TB] hold on idle");
        applyStimulus(7, 8, 0, 1, 0);
        applyStimulus(3, 3, 1, 0, 0);
        applyStimulus(9, 9, 1, 0, 0);

        $display("[TB] reset beats in_valid");
        applyStimulus(8, 8, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] illegal digits");
        applyStimulus(15, 15, 1, 1, 0);
        applyStimulus(2, 2, 0, 1, 0);
        applyStimulus(12, 3, 0, 1, 0);

        $display("[TB] mid-stream reset");
        applyStimulus(3, 4, 0, 1, 0);
        applyStimulus(6, 6, 0, 1, 1);
        applyStimulus(2, 5, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] random stream");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 1)), int'($urandom_range(0, 3) != 0), 0);
        end
        applyStimulus(0, 0, 0, 0, 0);

        compare("scoreboard_empty", 8'(sb.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
